// File: rtl/uart_alu_if.sv
// Purpose: command sequencer between the UART FIFOs and a combinational ALU (pops A, B, opcode; pushes result).
// Latency: 4 cycles from opcode byte visible in S_WAIT_OP to o_wr_uart; at least 2 cycles per received byte.
// Backpressure: waits in S_WAIT_x while i_rx_empty is high; holds in S_WAIT_TX while i_tx_full is high.
//
// Ports:
//   i_clk, i_reset (async, active-low)
//   RX FIFO : i_rx_empty, i_r_data (first-word fall-through), o_rd_uart (pop strobe)
//   TX FIFO : i_tx_full, o_wr_uart (push strobe), o_w_data
//   ALU     : o_data_a, o_data_b, o_opcode (registered), i_alu_result (combinational)
//   Status  : o_busy (low only in S_WAIT_A)
//
// Optional build macro UART_ALU_TIMEOUT_EN: abandons a partial command when the
// next operand/opcode byte does not arrive within TO_CYC clocks.

module uart_alu_if #(
  parameter int DBIT   = 8,
  parameter int OP_W   = 6,
  parameter int TO_CYC = 1000000,
  parameter int TO_W   = 20
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_rx_empty,
  input  logic [DBIT-1:0] i_r_data,
  output logic            o_rd_uart,
  input  logic            i_tx_full,
  output logic            o_wr_uart,
  output logic [DBIT-1:0] o_w_data,
  output logic [DBIT-1:0] o_data_a,
  output logic [DBIT-1:0] o_data_b,
  output logic [OP_W-1:0] o_opcode,
  input  logic [DBIT-1:0] i_alu_result,
  output logic            o_busy
);

  localparam logic [3:0] S_WAIT_A  = 4'd0;
  localparam logic [3:0] S_POP_A   = 4'd1;
  localparam logic [3:0] S_WAIT_B  = 4'd2;
  localparam logic [3:0] S_POP_B   = 4'd3;
  localparam logic [3:0] S_WAIT_OP = 4'd4;
  localparam logic [3:0] S_POP_OP  = 4'd5;
  localparam logic [3:0] S_CALC    = 4'd6;
  localparam logic [3:0] S_WAIT_TX = 4'd7;
  localparam logic [3:0] S_PUSH    = 4'd8;

  // The timeout counter must be able to reach TO_CYC-1.
  if ((64'd1 << TO_W) <= 64'(TO_CYC)) begin : g_to_w_chk
    $error("uart_alu_if: TO_W too narrow for TO_CYC");
  end

  logic [3:0]      state_q,  state_d;
  logic [DBIT-1:0] data_a_q, data_a_d;
  logic [DBIT-1:0] data_b_q, data_b_d;
  logic [OP_W-1:0] opcode_q, opcode_d;
  logic [DBIT-1:0] w_data_q, w_data_d;
  logic            to_hit;

`ifdef UART_ALU_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  assign to_hit = (to_cnt_q == TO_W'(TO_CYC - 1));

  // Counts only while starved mid-command; every other state (including the
  // POP states that precede each WAIT) forces zero, which gives the clear on
  // entry and on each pop.
  always_comb begin
    to_cnt_d = '0;
    if ((state_q == S_WAIT_B || state_q == S_WAIT_OP) && i_rx_empty && !to_hit) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    opcode_d = opcode_q;
    w_data_d = w_data_q;
    case (state_q)
      S_WAIT_A: begin
        if (!i_rx_empty) begin
          data_a_d = i_r_data;
          state_d  = S_POP_A;
        end
      end
      S_POP_A: state_d = S_WAIT_B;
      S_WAIT_B: begin
        if (!i_rx_empty) begin
          data_b_d = i_r_data;
          state_d  = S_POP_B;
        end else if (to_hit) begin
          // Abandon the partial command; registers keep their old values.
          state_d = S_WAIT_A;
        end
      end
      S_POP_B: state_d = S_WAIT_OP;
      S_WAIT_OP: begin
        if (!i_rx_empty) begin
          opcode_d = i_r_data[OP_W-1:0];
          state_d  = S_POP_OP;
        end else if (to_hit) begin
          state_d = S_WAIT_A;
        end
      end
      S_POP_OP: state_d = S_CALC;
      S_CALC: begin
        // ALU has had a full cycle to settle on the new operand registers.
        w_data_d = i_alu_result;
        state_d  = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (!i_tx_full) begin
          state_d = S_PUSH;
        end
      end
      S_PUSH:  state_d = S_WAIT_A;
      default: state_d = S_WAIT_A;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= S_WAIT_A;
      data_a_q <= '0;
      data_b_q <= '0;
      opcode_q <= '0;
      w_data_q <= '0;
    end else begin
      state_q  <= state_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      opcode_q <= opcode_d;
      w_data_q <= w_data_d;
    end
  end

  // Moore strobes: one cycle each, decoded straight from the state register.
  assign o_rd_uart = (state_q == S_POP_A) || (state_q == S_POP_B) || (state_q == S_POP_OP);
  assign o_wr_uart = (state_q == S_PUSH);
  assign o_busy    = (state_q != S_WAIT_A);
  assign o_data_a  = data_a_q;
  assign o_data_b  = data_b_q;
  assign o_opcode  = opcode_q;
  assign o_w_data  = w_data_q;

endmodule

// File: tb/tb_uart_alu_if.sv
module tb_uart_alu_if;

  localparam int DBIT   = 8;
  localparam int OP_W   = 6;
  localparam int TO_CYC = 16;
  localparam int TO_W   = 5;

  logic            i_clk = 1'b0;
  logic            i_reset;
  logic            i_rx_empty;
  logic [DBIT-1:0] i_r_data;
  logic            o_rd_uart;
  logic            i_tx_full;
  logic            o_wr_uart;
  logic [DBIT-1:0] o_w_data;
  logic [DBIT-1:0] o_data_a;
  logic [DBIT-1:0] o_data_b;
  logic [OP_W-1:0] o_opcode;
  logic [DBIT-1:0] i_alu_result;
  logic            o_busy;

  always #5 i_clk = ~i_clk;

  uart_alu_if #(.DBIT(DBIT), .OP_W(OP_W), .TO_CYC(TO_CYC), .TO_W(TO_W)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_rx_empty   (i_rx_empty),
    .i_r_data     (i_r_data),
    .o_rd_uart    (o_rd_uart),
    .i_tx_full    (i_tx_full),
    .o_wr_uart    (o_wr_uart),
    .o_w_data     (o_w_data),
    .o_data_a     (o_data_a),
    .o_data_b     (o_data_b),
    .o_opcode     (o_opcode),
    .i_alu_result (i_alu_result),
    .o_busy       (o_busy)
  );

  // Reference ALU (MIPS-style function codes), also used as the DUT's ALU.
  function automatic logic [7:0] alu_ref(logic [7:0] a, logic [7:0] b, logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h02:   return a >> b[2:0];
      6'h03:   return $signed(a) >>> b[2:0];
      default: return 8'h00;
    endcase
  endfunction

  assign i_alu_result = alu_ref(o_data_a, o_data_b, o_opcode);

  // RX FIFO model: first-word fall-through, popped by the monitor.
  logic [7:0] rx_mem [0:1023];
  int         rx_wp = 0;
  int         rx_rp = 0;
  assign i_rx_empty = (rx_wp == rx_rp);
  assign i_r_data   = rx_mem[rx_rp[9:0]];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] res;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int rd_cnt = 0;
  int tx_cnt = 0;

  task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor on the falling edge, mid-cycle, where the Moore strobes are stable.
  always @(negedge i_clk) begin : mon
    exp_t e;
    if (i_reset && o_rd_uart) begin
      check_eq("rx_pop_nonempty", i_rx_empty, 0);
      if (!i_rx_empty) rx_rp <= rx_rp + 1;
      rd_cnt <= rd_cnt + 1;
    end
    if (i_reset && o_wr_uart) begin
      check_eq("tx_push_not_full", i_tx_full, 0);
      check_eq("tx_push_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("tx_result", o_w_data, e.res);
        check_eq("tx_opnd_a", o_data_a, e.a);
        check_eq("tx_opnd_b", o_data_b, e.b);
        check_eq("tx_opcode", o_opcode, e.op);
      end
      tx_cnt <= tx_cnt + 1;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(negedge i_clk);
      #1;
    end
  endtask

  task automatic rx_push(logic [7:0] b);
    rx_mem[rx_wp[9:0]] = b;
    rx_wp = rx_wp + 1;
  endtask

  task automatic expect_cmd(logic [7:0] a, logic [7:0] b, logic [7:0] opb, logic [7:0] res);
    exp_t e;
    e.a = a;
    e.b = b;
    e.op = opb[5:0];
    e.res = res;
    exp_q.push_back(e);
  endtask

  task automatic wait_tx(int target, int budget, string tag);
    int k = 0;
    while (tx_cnt < target && k < budget) begin
      tick(1);
      k++;
    end
    check_eq(tag, tx_cnt >= target, 1);
  endtask

  task automatic check_all_zero(string tag);
    check_eq({tag, "_a"},    o_data_a, 0);
    check_eq({tag, "_b"},    o_data_b, 0);
    check_eq({tag, "_op"},   o_opcode, 0);
    check_eq({tag, "_wd"},   o_w_data, 0);
    check_eq({tag, "_rd"},   o_rd_uart, 0);
    check_eq({tag, "_wr"},   o_wr_uart, 0);
    check_eq({tag, "_busy"}, o_busy, 0);
  endtask

  initial begin
    int t0, r0, k;
    logic [5:0] ops [8];
    ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};

    i_reset   = 1'b0;
    i_tx_full = 1'b0;
    tick(2);
    check_all_zero("reset");
    i_reset = 1'b1;
    tick(2);

    // Single command with latency measurement on the opcode byte.
    t0 = tx_cnt;
    r0 = rd_cnt;
    expect_cmd(8'h05, 8'h03, 8'h20, 8'h08);
    rx_push(8'h05);
    rx_push(8'h03);
    tick(6);
    rx_push(8'h20);
    k = 0;
    while (tx_cnt == t0 && k < 20) begin
      tick(1);
      k++;
    end
    check_eq("single_latency", k, 4);
    check_eq("single_pops", rd_cnt - r0, 3);
    check_eq("single_wdata", o_w_data, 8'h08);
    tick(2);
    check_eq("single_idle", o_busy, 0);

    // Back-to-back: two commands preloaded; 9-cycle FSM path between pushes.
    t0 = tx_cnt;
    r0 = rd_cnt;
    expect_cmd(8'hFF, 8'h01, 8'h20, 8'h00);
    expect_cmd(8'h0F, 8'h0A, 8'h24, 8'h0A);
    rx_push(8'hFF); rx_push(8'h01); rx_push(8'h20);
    rx_push(8'h0F); rx_push(8'h0A); rx_push(8'h24);
    wait_tx(t0 + 1, 40, "b2b_first_push");
    k = 0;
    while (tx_cnt < t0 + 2 && k < 40) begin
      tick(1);
      k++;
    end
    check_eq("b2b_gap", k, 9);
    tick(2);
    check_eq("b2b_idle", o_busy, 0);
    check_eq("b2b_pops", rd_cnt - r0, 6);

    // TX backpressure across S_CALC.
    t0 = tx_cnt;
    i_tx_full = 1'b1;
    expect_cmd(8'h07, 8'h02, 8'h22, 8'h05);
    rx_push(8'h07); rx_push(8'h02); rx_push(8'h22);
    tick(50);
    check_eq("bp_no_push", tx_cnt, t0);
    check_eq("bp_busy", o_busy, 1);
    check_eq("bp_wdata_held", o_w_data, 8'h05);
    i_tx_full = 1'b0;
    // Full drops in the first cycle; the push occupies the second.
    k = 0;
    while (tx_cnt == t0 && k < 10) begin
      tick(1);
      k++;
    end
    check_eq("bp_release_lat", k, 1);

    // Bytes 100 cycles apart.
    t0 = tx_cnt;
    r0 = rd_cnt;
    expect_cmd(8'h05, 8'h03, 8'h20, 8'h08);
    rx_push(8'h05); tick(100); check_eq("gap_pops1", rd_cnt - r0, 1);
    rx_push(8'h03); tick(100); check_eq("gap_pops2", rd_cnt - r0, 2);
    rx_push(8'h20); tick(100); check_eq("gap_pops3", rd_cnt - r0, 3);
    check_eq("gap_push", tx_cnt - t0, 1);

    // Reset after operand B is popped.
    t0 = tx_cnt;
    r0 = rd_cnt;
    rx_push(8'h09); rx_push(8'h04);
    k = 0;
    while (rd_cnt - r0 < 2 && k < 20) begin
      tick(1);
      k++;
    end
    check_eq("rst_mid_popped", rd_cnt - r0, 2);
    tick(2);
    i_reset = 1'b0;
    #1;
    check_all_zero("rst_async");
    tick(2);
    i_reset = 1'b1;
    tick(3);
    check_eq("rst_no_push", tx_cnt, t0);
    expect_cmd(8'h02, 8'h02, 8'h20, 8'h04);
    rx_push(8'h02); rx_push(8'h02); rx_push(8'h20);
    wait_tx(t0 + 1, 40, "rst_after_push");

    // Stall after operand A.
    t0 = tx_cnt;
    rx_push(8'h05);
    tick(20);
`ifdef UART_ALU_TIMEOUT_EN
    check_eq("to_idle", o_busy, 0);
    check_eq("to_keep_a", o_data_a, 8'h05);
    expect_cmd(8'h01, 8'h01, 8'h20, 8'h02);
    rx_push(8'h01); rx_push(8'h01); rx_push(8'h20);
`else
    check_eq("nto_still_busy", o_busy, 1);
    expect_cmd(8'h05, 8'h01, 8'h20, 8'h06);
    rx_push(8'h01); rx_push(8'h20);
`endif
    wait_tx(t0 + 1, 40, "to_after_push");

    // Randomized commands with random byte gaps and TX full toggling.
    t0 = tx_cnt;
    for (int c = 0; c < 40; c++) begin
      logic [7:0] a, b, opb;
      a   = 8'($urandom);
      b   = 8'($urandom);
      opb = {2'($urandom), ops[$urandom_range(0, 7)]};
      expect_cmd(a, b, opb, alu_ref(a, b, opb[5:0]));
      for (int j = 0; j < 3; j++) begin
        int gap;
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          i_tx_full = ($urandom_range(0, 3) == 0);
          tick(1);
        end
        rx_push(j == 0 ? a : (j == 1 ? b : opb));
      end
    end
    k = 0;
    while (tx_cnt < t0 + 40 && k < 3000) begin
      i_tx_full = ($urandom_range(0, 3) == 0);
      tick(1);
      k++;
    end
    i_tx_full = 1'b0;
    check_eq("rand_all_pushed", tx_cnt - t0, 40);
    tick(5);
    check_eq("sb_drained", exp_q.size(), 0);
    check_eq("rx_drained", rx_rp, rx_wp);
    check_eq("final_idle", o_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
